// File: rtl/render_pkg.sv
// Shared state encoding and request indices for the paddle render handshake.
package render_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLR1 = 3'd1;
  localparam logic [STATE_W-1:0] ST_DRW1 = 3'd2;
  localparam logic [STATE_W-1:0] ST_CLR2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRW2 = 3'd4;
  localparam logic [STATE_W-1:0] ST_FIN  = 3'd5;

  localparam int unsigned REQ_NUM    = 4;
  localparam int unsigned REQ_CLEAR1 = 0;
  localparam int unsigned REQ_DRAW1  = 1;
  localparam int unsigned REQ_CLEAR2 = 2;
  localparam int unsigned REQ_DRAW2  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE,
    S_CLR1 = ST_CLR1,
    S_DRW1 = ST_DRW1,
    S_CLR2 = ST_CLR2,
    S_DRW2 = ST_DRW2,
    S_FIN  = ST_FIN
  } state_e;

  // One request line per handshake state; IDLE and FIN request nothing.
  function automatic logic [REQ_NUM-1:0] req_of(input state_e s);
    logic [REQ_NUM-1:0] r;
    r = '0;
    case (s)
      S_CLR1:  r[REQ_CLEAR1] = 1'b1;
      S_DRW1:  r[REQ_DRAW1]  = 1'b1;
      S_CLR2:  r[REQ_CLEAR2] = 1'b1;
      S_DRW2:  r[REQ_DRAW2]  = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/render_watchdog.sv
// Per-state request watchdog: counts cycles in a request state and forces an
// advance at TIMEOUT-1, latching a sticky error flag.
module render_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic active,
  input  logic restart,
  output logic expire_c,
  output logic timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire_c = active && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (restart || !active) cnt <= '0;
      else                    cnt <= cnt + CNT_W'(1);
      if (expire_c) timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// Frame-level initiator for the paddle clear/draw handshake.
// Optional request watchdog is built when RENDER_TIMEOUT_EN is defined.
module render_scheduler
  import render_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned OVR_W   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             frameTick,
  input  logic             moved1,
  input  logic             moved2,
  input  logic             done_clear1,
  input  logic             done_draw1,
  input  logic             done_clear2,
  input  logic             done_draw2,
  output logic             pulse_clear1,
  output logic             pulse_draw1,
  output logic             pulse_clear2,
  output logic             pulse_draw2,
  output logic             busy,
  output logic             frame_done,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             timeout_err
);

  state_e             state, state_next;
  logic               pending, first, m2;
  logic               start_c, expire_c;
  logic [REQ_NUM-1:0] req_next_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (frameTick || pending)) begin
          start_c = 1'b1;
          if (moved1 || first)      state_next = S_CLR1;
          else if (moved2 || first) state_next = S_CLR2;
          else                      state_next = S_FIN;
        end
      end
      S_CLR1:  if (done_clear1 || expire_c) state_next = S_DRW1;
      S_DRW1:  if (done_draw1 || expire_c)  state_next = m2 ? S_CLR2 : S_FIN;
      S_CLR2:  if (done_clear2 || expire_c) state_next = S_DRW2;
      S_DRW2:  if (done_draw2 || expire_c)  state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    req_next_c = req_of(state_next);
  end

  // Frame bookkeeping and registered outputs; requests/busy follow state_next
  // so they line up with the state register, frame_done trails FIN by a cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending      <= 1'b0;
      first        <= 1'b1;
      m2           <= 1'b0;
      pulse_clear1 <= 1'b0;
      pulse_draw1  <= 1'b0;
      pulse_clear2 <= 1'b0;
      pulse_draw2  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      if (start_c) begin
        pending <= 1'b0;
        first   <= 1'b0;
        m2      <= moved2 | first;
      end else if (frameTick) begin
        pending <= 1'b1;
      end
      if (frameTick && (state != S_IDLE) && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      pulse_clear1 <= req_next_c[REQ_CLEAR1];
      pulse_draw1  <= req_next_c[REQ_DRAW1];
      pulse_clear2 <= req_next_c[REQ_CLEAR2];
      pulse_draw2  <= req_next_c[REQ_DRAW2];
      busy         <= (state_next != S_IDLE);
      frame_done   <= (state == S_FIN);
    end
  end

`ifdef RENDER_TIMEOUT_EN
  logic wd_active_c, wd_restart_c;

  assign wd_active_c  = state inside {S_CLR1, S_DRW1, S_CLR2, S_DRW2};
  assign wd_restart_c = (state_next != state);

  render_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .resetn      (resetn),
    .active      (wd_active_c),
    .restart     (wd_restart_c),
    .expire_c    (expire_c),
    .timeout_err (timeout_err)
  );
`else
  assign expire_c    = 1'b0;
  assign timeout_err = 1'b0;

  // TIMEOUT only sizes the watchdog; without it requests wait indefinitely.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler: stimulus pushes expected request
// rises and frame_done pulses with their cycle numbers; a monitor pops them.
module tb_render_scheduler;
  import render_pkg::*;

  localparam int unsigned OVR_W = 8;
  localparam int K_C1 = 1;
  localparam int K_D1 = 2;
  localparam int K_C2 = 3;
  localparam int K_D2 = 4;
  localparam int K_FD = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  logic frameTick = 1'b0;
  logic moved1 = 1'b0;
  logic moved2 = 1'b0;
  logic done_clear1 = 1'b0;
  logic done_draw1 = 1'b0;
  logic done_clear2 = 1'b0;
  logic done_draw2 = 1'b0;
  logic pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2;
  logic busy, frame_done, timeout_err;
  logic [OVR_W-1:0] overrun_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t sb[$];

  int lat = 3;
  logic [3:0] hold_mask = 4'b0000;
  bit stray_en = 1'b1;

  render_scheduler #(
    .TIMEOUT (16),
    .OVR_W   (OVR_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .frameTick    (frameTick),
    .moved1       (moved1),
    .moved2       (moved2),
    .done_clear1  (done_clear1),
    .done_draw1   (done_draw1),
    .done_clear2  (done_clear2),
    .done_draw2   (done_draw2),
    .pulse_clear1 (pulse_clear1),
    .pulse_draw1  (pulse_draw1),
    .pulse_clear2 (pulse_clear2),
    .pulse_draw2  (pulse_draw2),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int kind);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: frame_done first (it belongs to the older sequence), then rises.
  logic [3:0] mon_prev = 4'b0000;
  always @(negedge clk) begin : monitor
    logic [3:0] v;
    v = '0;
    v[REQ_CLEAR1] = pulse_clear1;
    v[REQ_DRAW1]  = pulse_draw1;
    v[REQ_CLEAR2] = pulse_clear2;
    v[REQ_DRAW2]  = pulse_draw2;
    if (resetn) begin
      if (v != 4'b0000) begin
        checks++;
        if ($countones(v) != 1) begin
          errors++;
          $display("FAIL onehot: got requests %b expected a single one at cycle %0d", v, cyc);
        end
      end
      if (frame_done) sb_check(K_FD);
      for (int i = 0; i < 4; i++)
        if (v[i] && !mon_prev[i]) sb_check(i + 1);
    end
    mon_prev = v;
  end

  // Responder: each request lasts lat cycles; a stray non-matching done is
  // pulsed in the first cycle of every request.
  logic [3:0] resp_prev = 4'b0000;
  int age = 0;
  always @(negedge clk) begin : responder
    logic [3:0] v, d;
    v = '0;
    d = '0;
    v[REQ_CLEAR1] = pulse_clear1;
    v[REQ_DRAW1]  = pulse_draw1;
    v[REQ_CLEAR2] = pulse_clear2;
    v[REQ_DRAW2]  = pulse_draw2;
    if (v != 4'b0000) begin
      age = (v != resp_prev) ? 1 : age + 1;
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (age == lat && !hold_mask[i]) d[i] = 1'b1;
          if (age == 1 && stray_en) d[(i + 1) % 4] = 1'b1;
        end
      end
    end else begin
      age = 0;
    end
    resp_prev   = v;
    done_clear1 = d[REQ_CLEAR1];
    done_draw1  = d[REQ_DRAW1];
    done_clear2 = d[REQ_CLEAR2];
    done_draw2  = d[REQ_DRAW2];
  end

  task automatic do_tick(input logic m1, input logic m2, output int t);
    @(posedge clk);
    #1;
    frameTick = 1'b1;
    moved1    = m1;
    moved2    = m2;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    t = cyc;
  endtask

  task automatic raw_tick();
    frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
  endtask

  task automatic at_cycle(input int k);
    int n;
    n = 0;
    while (cyc < k && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || frame_done || sb.size() != 0) && n < 200);
    check("idle_reached", (busy || frame_done || sb.size() != 0) ? 0 : 1, 1);
  endtask

  task automatic push_full(input int t);
    push(K_C1, t);
    push(K_D1, t + 3);
    push(K_C2, t + 6);
    push(K_D2, t + 9);
    push(K_FD, t + 13);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse_clear1"}, int'(pulse_clear1), 0);
    check({tag, "_pulse_draw1"}, int'(pulse_draw1), 0);
    check({tag, "_pulse_clear2"}, int'(pulse_clear2), 0);
    check({tag, "_pulse_draw2"}, int'(pulse_draw2), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_overrun_cnt"}, int'(overrun_cnt), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    int t, u, dly;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // First frame after reset draws both paddles regardless of moved.
    do_tick(1'b0, 1'b0, t);
    push_full(t);
    wait_idle();
    check("overrun_after_first", int'(overrun_cnt), 0);
    check("timeout_err_normal", int'(timeout_err), 0);

    // Only paddle 1 moved.
    do_tick(1'b1, 1'b0, t);
    push(K_C1, t);
    push(K_D1, t + 3);
    push(K_FD, t + 7);
    wait_idle();

    // Nothing moved: straight to FIN.
    do_tick(1'b0, 1'b0, t);
    check("busy_empty_frame", int'(busy), 1);
    push(K_FD, t + 1);
    wait_idle();

    // Three ticks while busy (last one in FIN) -> one pending rerun.
    do_tick(1'b0, 1'b1, t);
    push(K_C2, t);
    push(K_D2, t + 3);
    push(K_FD, t + 7);
    push(K_C1, t + 8);
    push(K_D1, t + 11);
    push(K_FD, t + 15);
    moved1 = 1'b1;
    moved2 = 1'b0;
    at_cycle(t + 1);
    raw_tick();
    at_cycle(t + 3);
    raw_tick();
    at_cycle(t + 6);
    raw_tick();
    at_cycle(t + 7);
    check("idle_gap_busy", int'(busy), 0);
    check("overrun_three", int'(overrun_cnt), 3);
    at_cycle(t + 8);
    check("pending_restart_busy", int'(busy), 1);
    wait_idle();
    at_cycle(cyc + 4);
    check("no_second_rerun", int'(busy), 0);
    check("overrun_held", int'(overrun_cnt), 3);

    // enable dropped mid-DRW1 does not abort; a tick while disabled waits.
    do_tick(1'b1, 1'b0, t);
    push(K_C1, t);
    push(K_D1, t + 3);
    push(K_FD, t + 7);
    at_cycle(t + 4);
    enable = 1'b0;
    wait_idle();
    do_tick(1'b1, 1'b1, u);
    at_cycle(u + 3);
    check("disabled_no_start", int'(busy), 0);
    check("overrun_idle_tick", int'(overrun_cnt), 3);
    moved1 = 1'b0;
    moved2 = 1'b1;
    enable = 1'b1;
    push(K_C2, u + 4);
    push(K_D2, u + 7);
    push(K_FD, u + 11);
    wait_idle();

    // Reset in the middle of DRW1 (after a watchdog expiry when built in).
`ifdef RENDER_TIMEOUT_EN
    hold_mask = 4'b0001;
    dly = 16;
`else
    dly = 3;
`endif
    do_tick(1'b1, 1'b0, t);
    push(K_C1, t);
    push(K_D1, t + dly);
    at_cycle(t + dly + 1);
`ifdef RENDER_TIMEOUT_EN
    check("timeout_err_set", int'(timeout_err), 1);
`endif
    check("drw1_before_reset", int'(pulse_draw1), 1);
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    hold_mask = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;

    // first is set again by reset.
    do_tick(1'b0, 1'b0, t);
    push_full(t);
    wait_idle();
    check("timeout_err_final", int'(timeout_err), 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500000");
    $fatal(1, "bench timed out");
  end

endmodule
